word_byte_serializer: RTL



---
 rtl/word_byte_serializer_if.sv | 27 ++
 rtl/word_byte_serializer.sv | 103 ++++++++++
 2 files changed

// File: rtl/word_byte_serializer_if.sv
// Control and memory-side signal bundle for word_byte_serializer.
// master = register-bank/memory side (the driver), slave = serializer.
interface word_byte_serializer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  Start;
    logic [1:0]            Size;
    logic [31:0]           Word;
    logic [ADDR_WIDTH-1:0] BaseAddr;
    logic                  MemWr;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [7:0]            MemData;
    logic                  MemReady;
    logic                  Busy;
    logic                  Done;
    logic                  Err;

    modport master (
        output Start, Size, Word, BaseAddr, MemReady,
        input  MemWr, MemAddr, MemData, Busy, Done, Err
    );

    modport slave (
        input  Start, Size, Word, BaseAddr, MemReady,
        output MemWr, MemAddr, MemData, Busy, Done, Err
    );
endinterface

// File: rtl/word_byte_serializer.sv
// Splits a 32-bit word into 1/2/4 big-endian byte writes to consecutive
// addresses, with Start/Busy/Done control and MemWr/MemReady memory handshake.
module word_byte_serializer #(
    parameter int ADDR_WIDTH = 32
) (
    input logic                 clock,
    input logic                 reset,
    word_byte_serializer_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]            state;
    logic [31:0]           shreg;
    logic [1:0]            count;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            data_q;
    logic                  wr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic [31:0]           aligned;
    logic [1:0]            remaining;

    // Left-align the bytes to send so the first one is always in [31:24].
    always_comb begin
        aligned   = bus.Word;
        remaining = 2'd3;
        case (bus.Size)
            2'b00: begin
                aligned   = {bus.Word[7:0], 24'h000000};
                remaining = 2'd0;
            end
            2'b01: begin
                aligned   = {bus.Word[15:0], 16'h0000};
                remaining = 2'd1;
            end
            default: begin
                aligned   = bus.Word;
                remaining = 2'd3;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            count  <= '0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        if (bus.Size == 2'b11) begin
                            err_q <= 1'b1;
                        end else begin
                            // shreg keeps only the bytes still to be presented
                            data_q <= aligned[31:24];
                            shreg  <= {aligned[23:0], 8'h00};
                            count  <= remaining;
                            addr_q <= bus.BaseAddr;
                            wr_q   <= 1'b1;
                            busy_q <= 1'b1;
                            state  <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (bus.MemReady) begin
                        if (count == 2'd0) begin
                            wr_q   <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            data_q <= shreg[31:24];
                            shreg  <= {shreg[23:0], 8'h00};
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                            count  <= count - 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.MemWr   = wr_q;
    assign bus.MemAddr = addr_q;
    assign bus.MemData = data_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Err     = err_q;
endmodule
